// File: rtl/ptw_arbiter_if.sv
// ptw_arbiter_if: bundles the TLB-side and PTW-side handshakes of ptw_arbiter.
// Signal names carry the arbiter's point of view (_i = into the arbiter).
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clk edge where both valid and ready are 1; the source holds valid and
// its payload stable until that edge, and ready may depend combinationally on
// valid but valid never depends on ready.
interface ptw_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 20
);
  // TLB requester side
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*VPN_W-1:0] req_vpn_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       resp_valid_o;
  logic [NUM_REQ-1:0]       resp_ready_i;
  logic [PPN_W-1:0]         resp_ppn_o;
  logic                     resp_fault_o;
  // page-table walker side
  logic                     ptw_req_valid_o;
  logic                     ptw_req_ready_i;
  logic [VPN_W-1:0]         ptw_req_vpn_o;
  logic                     ptw_resp_valid_i;
  logic                     ptw_resp_ready_o;
  logic [PPN_W-1:0]         ptw_resp_ppn_i;
  logic                     ptw_resp_fault_i;

  // the arbiter itself
  modport slave (
    input  req_valid_i, req_vpn_i, resp_ready_i,
    input  ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_ppn_i, ptw_resp_fault_i,
    output req_ready_o, resp_valid_o, resp_ppn_o, resp_fault_o,
    output ptw_req_valid_o, ptw_req_vpn_o, ptw_resp_ready_o
  );

  // the surrounding TLBs and walker
  modport master (
    output req_valid_i, req_vpn_i, resp_ready_i,
    output ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_ppn_i, ptw_resp_fault_i,
    input  req_ready_o, resp_valid_o, resp_ppn_o, resp_fault_o,
    input  ptw_req_valid_o, ptw_req_vpn_o, ptw_resp_ready_o
  );
endinterface

// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker among NUM_REQ TLB miss requesters.
// One walk is outstanding at a time: IDLE (pick winner) -> ISSUE (send VPN)
// -> WAIT (collect PTW result) -> RESP (return result to the granted TLB).
// Build option PTW_ARB_FIXED_PRIO_EN: lowest index always wins and no
// round-robin pointer exists; default build uses round-robin arbitration.
module ptw_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 20,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ptw_arbiter_if.slave    bus,
  output logic            busy_o,
  output logic [ID_W-1:0] grant_id_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   grant_q;
  logic [VPN_W-1:0]  vpn_q;
  logic [PPN_W-1:0]  ppn_q;
  logic              fault_q;

  logic              any_req;
  logic [ID_W-1:0]   win_id;
  logic [VPN_W-1:0]  win_vpn;
  logic              req_fire;
  logic              ptw_req_fire;
  logic              ptw_resp_fire;
  logic              resp_fire;

`ifdef PTW_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest valid index wins last.
  always_comb begin
    win_id  = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid_i[i]) begin
        win_id  = ID_W'(i);
        any_req = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q;

  // Requester index reached by stepping offset places past base, wrapping.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                               input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Round-robin: first valid requester found walking upward from rr_ptr.
  always_comb begin
    win_id  = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && bus.req_valid_i[rr_index(rr_ptr_q, i)]) begin
        win_id  = rr_index(rr_ptr_q, i);
        any_req = 1'b1;
      end
    end
  end

  // Pointer moves past the served requester only when its response completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (resp_fire) begin
      rr_ptr_q <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end
`endif

  // Select the winner's VPN out of the packed request bus.
  always_comb begin
    win_vpn = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) win_vpn = bus.req_vpn_i[i*VPN_W +: VPN_W];
    end
  end

  assign req_fire      = (state_q == S_IDLE)  && any_req;
  assign ptw_req_fire  = (state_q == S_ISSUE) && bus.ptw_req_ready_i;
  assign ptw_resp_fire = (state_q == S_WAIT)  && bus.ptw_resp_valid_i;
  assign resp_fire     = (state_q == S_RESP)  && bus.resp_ready_i[grant_q];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; any unexpected encoding falls back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = req_fire      ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = ptw_req_fire  ? S_WAIT  : S_ISSUE;
      S_WAIT:  state_d = ptw_resp_fire ? S_RESP  : S_WAIT;
      S_RESP:  state_d = resp_fire     ? S_IDLE  : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Walk payload: grant/VPN captured at accept, result captured from the PTW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      vpn_q   <= '0;
      ppn_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      if (req_fire) begin
        grant_q <= win_id;
        vpn_q   <= win_vpn;
      end
      if (ptw_resp_fire) begin
        ppn_q   <= bus.ptw_resp_ppn_i;
        fault_q <= bus.ptw_resp_fault_i;
      end
    end
  end

  // Outputs decode from registered state; req_ready also needs the live
  // request vector and is held off while reset is asserted.
  always_comb begin
    bus.req_ready_o = '0;
    if (req_fire && rst_n) bus.req_ready_o[win_id] = 1'b1;
    bus.resp_valid_o = '0;
    if (state_q == S_RESP) bus.resp_valid_o[grant_q] = 1'b1;
    bus.resp_ppn_o       = ppn_q;
    bus.resp_fault_o     = fault_q;
    bus.ptw_req_valid_o  = (state_q == S_ISSUE);
    bus.ptw_req_vpn_o    = vpn_q;
    bus.ptw_resp_ready_o = (state_q == S_WAIT);
    busy_o               = (state_q != S_IDLE);
    grant_id_o           = grant_q;
    state_o              = state_q;
  end

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter: vector table, hand-built corner sequences and a randomized
// run against a transaction-level model of ptw_arbiter (2 requesters).
module tb_ptw_arbiter;
  localparam int NUM_REQ = 2;
  localparam int VPN_W   = 20;
  localparam int PPN_W   = 20;
  localparam int ID_W    = 1;
  localparam int SB_W    = 1 + PPN_W + ID_W;
`ifdef PTW_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            busy;
  logic [ID_W-1:0] grant_id;
  logic [1:0]      state_dbg;

  ptw_arbiter_if #(.NUM_REQ(NUM_REQ), .VPN_W(VPN_W), .PPN_W(PPN_W)) bus ();

  ptw_arbiter #(.NUM_REQ(NUM_REQ), .VPN_W(VPN_W), .PPN_W(PPN_W), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .grant_id_o (grant_id),
    .state_o    (state_dbg)
  );

  int tests_run = 0;
  int fails = 0;
  int rr_m = 0;                 // model's round-robin start index
  logic [SB_W-1:0] exp_q[$];    // {fault, ppn, id} of walks in flight

  typedef struct {
    bit         rst_before;
    logic [1:0] rv;
    logic [19:0] v0, v1;
    logic       prq, prv;
    logic [19:0] ppn;
    logic       f;
    logic [1:0] rr;
    logic [1:0] e_rq;
    logic       e_pv;
    logic [19:0] e_vpn;
    logic       e_pr;
    logic [1:0] e_rv;
    logic [19:0] e_ppn;
    logic       e_f, e_busy, e_g;
  } vec_t;
  vec_t vecs[$];

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int k);
    logic [NUM_REQ-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic set_vpn(input int k, input logic [VPN_W-1:0] v);
    bus.req_vpn_i[k*VPN_W +: VPN_W] = v;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i      = '0;
    bus.resp_ready_i     = '0;
    bus.ptw_req_ready_i  = 1'b0;
    bus.ptw_resp_valid_i = 1'b0;
    bus.ptw_resp_ppn_i   = '0;
    bus.ptw_resp_fault_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  bus.req_ready_o, 0);
    check({tag, "_resp_valid"}, bus.resp_valid_o, 0);
    check({tag, "_resp_ppn"},   bus.resp_ppn_o, 0);
    check({tag, "_resp_fault"}, bus.resp_fault_o, 0);
    check({tag, "_ptw_req_v"},  bus.ptw_req_valid_o, 0);
    check({tag, "_ptw_vpn"},    bus.ptw_req_vpn_o, 0);
    check({tag, "_ptw_resp_r"}, bus.ptw_resp_ready_o, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_grant"},      grant_id, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
  endtask

  // Full minimum-latency walk for a single requester, checked cycle by cycle.
  task automatic do_walk(input int id, input logic [VPN_W-1:0] vpn,
                         input logic [PPN_W-1:0] ppn, input logic fault);
    idle_inputs();
    set_vpn(id, vpn);
    bus.req_valid_i = onehot(id);
    #1 check("walk_accept", bus.req_ready_o, onehot(id));
    next_cycle();
    bus.req_valid_i = '0;
    bus.ptw_req_ready_i = 1'b1;
    #1 check("walk_ptw_req_v", bus.ptw_req_valid_o, 1);
    check("walk_ptw_vpn", bus.ptw_req_vpn_o, vpn);
    check("walk_grant", grant_id, id);
    next_cycle();
    bus.ptw_req_ready_i = 1'b0;
    bus.ptw_resp_valid_i = 1'b1;
    bus.ptw_resp_ppn_i = ppn;
    bus.ptw_resp_fault_i = fault;
    #1 check("walk_ptw_resp_r", bus.ptw_resp_ready_o, 1);
    next_cycle();
    bus.ptw_resp_valid_i = 1'b0;
    bus.resp_ready_i = onehot(id);
    #1 check("walk_resp_v", bus.resp_valid_o, onehot(id));
    check("walk_resp_ppn", bus.resp_ppn_o, ppn);
    check("walk_resp_fault", bus.resp_fault_o, fault);
    next_cycle();
    bus.resp_ready_i = '0;
    #1 check("walk_done_busy", busy, 0);
    rr_m = FIXED ? 0 : (id + 1) % NUM_REQ;
  endtask

  function automatic void add_vec(bit rb, logic [1:0] rv, logic [19:0] v0, logic [19:0] v1,
      logic prq, logic prv, logic [19:0] ppn, logic f, logic [1:0] rr,
      logic [1:0] e_rq, logic e_pv, logic [19:0] e_vpn, logic e_pr, logic [1:0] e_rv,
      logic [19:0] e_ppn, logic e_f, logic e_busy, logic e_g);
    vec_t v;
    v.rst_before = rb; v.rv = rv; v.v0 = v0; v.v1 = v1; v.prq = prq; v.prv = prv;
    v.ppn = ppn; v.f = f; v.rr = rr; v.e_rq = e_rq; v.e_pv = e_pv; v.e_vpn = e_vpn;
    v.e_pr = e_pr; v.e_rv = e_rv; v.e_ppn = e_ppn; v.e_f = e_f; v.e_busy = e_busy; v.e_g = e_g;
    vecs.push_back(v);
  endfunction

  // random-phase working state
  logic [NUM_REQ-1:0] pend, newb;
  logic [VPN_W-1:0]   vpns[NUM_REQ];
  logic [PPN_W-1:0]   r_ppn;
  logic               r_fault;
  logic [SB_W-1:0]    item;
  int                 win, start, d, k;
  logic               g2;
  logic [1:0]         rq2;
  logic [19:0]        v2;

  initial begin
    bus.req_vpn_i = '0;
    do_reset();

    // ---------------- vector table ----------------
    g2  = FIXED ? 1'b0 : 1'b1;
    rq2 = FIXED ? 2'b01 : 2'b10;
    v2  = FIXED ? 20'h1 : 20'h2;
    // single miss, minimum latency
    add_vec(1, 2'b01, 20'h12345, 20'h0, 1, 0, 20'hABCDE, 0, 2'b00, 2'b01, 0, 20'h0,     0, 2'b00, 20'h0,     0, 0, 0);
    add_vec(0, 2'b00, 20'h12345, 20'h0, 1, 0, 20'hABCDE, 0, 2'b00, 2'b00, 1, 20'h12345, 0, 2'b00, 20'h0,     0, 1, 0);
    add_vec(0, 2'b00, 20'h12345, 20'h0, 0, 1, 20'hABCDE, 0, 2'b00, 2'b00, 0, 20'h0,     1, 2'b00, 20'h0,     0, 1, 0);
    add_vec(0, 2'b00, 20'h12345, 20'h0, 0, 0, 20'hABCDE, 0, 2'b01, 2'b00, 0, 20'h0,     0, 2'b01, 20'hABCDE, 0, 1, 0);
    add_vec(0, 2'b00, 20'h12345, 20'h0, 0, 0, 20'hABCDE, 0, 2'b00, 2'b00, 0, 20'h0,     0, 2'b00, 20'h0,     0, 0, 0);
    // contention from reset, both held valid, stray ptw_resp_valid held high
    add_vec(1, 2'b11, 20'h1, 20'h2, 1, 1, 20'h100, 0, 2'b11, 2'b01, 0, 20'h0, 0, 2'b00, 20'h0,   0, 0, 0);
    add_vec(0, 2'b11, 20'h1, 20'h2, 1, 1, 20'h100, 0, 2'b11, 2'b00, 1, 20'h1, 0, 2'b00, 20'h0,   0, 1, 0);
    add_vec(0, 2'b11, 20'h1, 20'h2, 1, 1, 20'h100, 0, 2'b11, 2'b00, 0, 20'h0, 1, 2'b00, 20'h0,   0, 1, 0);
    add_vec(0, 2'b11, 20'h1, 20'h2, 1, 1, 20'h100, 0, 2'b11, 2'b00, 0, 20'h0, 0, 2'b01, 20'h100, 0, 1, 0);
    add_vec(0, 2'b11, 20'h1, 20'h2, 1, 1, 20'h100, 0, 2'b11, rq2,   0, 20'h0, 0, 2'b00, 20'h0,   0, 0, 0);
    add_vec(0, 2'b11, 20'h1, 20'h2, 1, 1, 20'h100, 0, 2'b11, 2'b00, 1, v2,    0, 2'b00, 20'h0,   0, 1, g2);
    add_vec(0, 2'b11, 20'h1, 20'h2, 1, 1, 20'h100, 0, 2'b11, 2'b00, 0, 20'h0, 1, 2'b00, 20'h0,   0, 1, g2);
    add_vec(0, 2'b11, 20'h1, 20'h2, 1, 1, 20'h100, 0, 2'b11, 2'b00, 0, 20'h0, 0, rq2,   20'h100, 0, 1, g2);
    add_vec(0, 2'b11, 20'h1, 20'h2, 1, 1, 20'h100, 0, 2'b11, 2'b01, 0, 20'h0, 0, 2'b00, 20'h0,   0, 0, g2);

    foreach (vecs[n]) begin
      if (vecs[n].rst_before) do_reset();
      bus.req_valid_i      = vecs[n].rv;
      set_vpn(0, vecs[n].v0);
      set_vpn(1, vecs[n].v1);
      bus.ptw_req_ready_i  = vecs[n].prq;
      bus.ptw_resp_valid_i = vecs[n].prv;
      bus.ptw_resp_ppn_i   = vecs[n].ppn;
      bus.ptw_resp_fault_i = vecs[n].f;
      bus.resp_ready_i     = vecs[n].rr;
      #1;
      check($sformatf("vec%0d_req_ready", n), bus.req_ready_o, vecs[n].e_rq);
      check($sformatf("vec%0d_ptw_req_v", n), bus.ptw_req_valid_o, vecs[n].e_pv);
      check($sformatf("vec%0d_ptw_resp_r", n), bus.ptw_resp_ready_o, vecs[n].e_pr);
      check($sformatf("vec%0d_resp_v", n), bus.resp_valid_o, vecs[n].e_rv);
      check($sformatf("vec%0d_busy", n), busy, vecs[n].e_busy);
      check($sformatf("vec%0d_grant", n), grant_id, vecs[n].e_g);
      if (vecs[n].e_pv) check($sformatf("vec%0d_ptw_vpn", n), bus.ptw_req_vpn_o, vecs[n].e_vpn);
      if (vecs[n].e_rv != 0) begin
        check($sformatf("vec%0d_resp_ppn", n), bus.resp_ppn_o, vecs[n].e_ppn);
        check($sformatf("vec%0d_resp_fault", n), bus.resp_fault_o, vecs[n].e_f);
      end
      next_cycle();
    end

    // ---------------- backpressure ----------------
    do_reset();
    set_vpn(0, 20'h5A5A5);
    set_vpn(1, 20'h33333);
    bus.req_valid_i = 2'b01;
    #1 check("bp_accept", bus.req_ready_o, 2'b01);
    next_cycle();
    bus.req_valid_i = 2'b10;
    repeat (5) begin
      #1 check("bp_ptw_req_v", bus.ptw_req_valid_o, 1);
      check("bp_ptw_vpn", bus.ptw_req_vpn_o, 20'h5A5A5);
      check("bp_no_ready", bus.req_ready_o, 0);
      check("bp_busy", busy, 1);
      next_cycle();
    end
    bus.ptw_req_ready_i = 1'b1;
    #1 check("bp_ptw_req_v_last", bus.ptw_req_valid_o, 1);
    next_cycle();
    bus.ptw_req_ready_i = 1'b0;
    bus.ptw_resp_valid_i = 1'b1;
    bus.ptw_resp_ppn_i = 20'h77777;
    #1 check("bp_ptw_resp_r", bus.ptw_resp_ready_o, 1);
    next_cycle();
    bus.ptw_resp_valid_i = 1'b0;
    bus.ptw_resp_ppn_i = 20'h0;
    bus.resp_ready_i = 2'b10;            // non-granted ready must be ignored
    repeat (3) begin
      #1 check("bp_resp_v", bus.resp_valid_o, 2'b01);
      check("bp_resp_ppn", bus.resp_ppn_o, 20'h77777);
      check("bp_no_ready_resp", bus.req_ready_o, 0);
      next_cycle();
    end
    bus.resp_ready_i = 2'b01;
    #1 check("bp_resp_v_last", bus.resp_valid_o, 2'b01);
    next_cycle();

    // ---------------- fault for requester 1, stray resp_ready[0] ----------------
    bus.resp_ready_i = 2'b00;
    #1 check("flt_accept", bus.req_ready_o, 2'b10);
    check("flt_idle_busy", busy, 0);
    next_cycle();
    bus.req_valid_i = 2'b00;
    bus.ptw_req_ready_i = 1'b1;
    #1 check("flt_ptw_vpn", bus.ptw_req_vpn_o, 20'h33333);
    check("flt_grant", grant_id, 1);
    next_cycle();
    bus.ptw_req_ready_i = 1'b0;
    bus.ptw_resp_valid_i = 1'b1;
    bus.ptw_resp_ppn_i = 20'h0;
    bus.ptw_resp_fault_i = 1'b1;
    next_cycle();
    bus.ptw_resp_valid_i = 1'b0;
    bus.ptw_resp_fault_i = 1'b0;
    bus.resp_ready_i = 2'b01;
    repeat (2) begin
      #1 check("flt_resp_v", bus.resp_valid_o, 2'b10);
      check("flt_fault", bus.resp_fault_o, 1);
      check("flt_ppn", bus.resp_ppn_o, 0);
      check("flt_busy", busy, 1);
      next_cycle();
    end
    bus.resp_ready_i = 2'b10;
    next_cycle();
    bus.resp_ready_i = 2'b00;
    #1 check("flt_done_busy", busy, 0);
    check("flt_done_resp_v", bus.resp_valid_o, 0);

    // ---------------- stray PTW response in IDLE ----------------
    bus.ptw_resp_valid_i = 1'b1;
    bus.ptw_resp_ppn_i = 20'hFFFFF;
    #1 check("stray_ptw_resp_r", bus.ptw_resp_ready_o, 0);
    next_cycle();
    bus.ptw_resp_valid_i = 1'b0;
    #1 check("stray_busy", busy, 0);
    check("stray_resp_v", bus.resp_valid_o, 0);
    check("stray_ppn_kept", bus.resp_ppn_o, 0);
    rr_m = 0;

    // ---------------- reset mid-walk ----------------
    do_walk(0, 20'h0BEEF, 20'h11111, 1'b0);
    set_vpn(0, 20'h22222);
    bus.req_valid_i = 2'b01;
    #1 check("mw_accept", bus.req_ready_o, 2'b01);
    next_cycle();
    set_vpn(1, 20'h44444);
    bus.req_valid_i = 2'b10;
    bus.ptw_req_ready_i = 1'b1;
    #1 check("mw_ptw_vpn", bus.ptw_req_vpn_o, 20'h22222);
    next_cycle();
    bus.ptw_req_ready_i = 1'b0;
    #1 check("mw_wait", bus.ptw_resp_ready_o, 1);
    rst_n = 1'b0;
    #1 check_all_zero("mw_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
    bus.req_valid_i = 2'b11;
    #1 check("mw_rr_restart", bus.req_ready_o, 2'b01);
    do_walk(1, 20'h44444, 20'h55555, 1'b0);

    // ---------------- randomized run against transaction model ----------------
    pend = '0;
    for (int t = 0; t < 60; t++) begin
      idle_inputs();
      newb = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)) & ~pend;
      if ((pend | newb) == 0) newb = onehot($urandom_range(0, NUM_REQ - 1));
      for (int j = 0; j < NUM_REQ; j++) begin
        if (newb[j]) begin
          vpns[j] = VPN_W'($urandom);
          set_vpn(j, vpns[j]);
        end
      end
      pend = pend | newb;
      bus.req_valid_i = pend;
      #1;
      start = FIXED ? 0 : rr_m;
      win = -1;
      for (int s = 0; s < NUM_REQ; s++) begin
        k = (start + s) % NUM_REQ;
        if (win < 0 && pend[k]) win = k;
      end
      check("rnd_req_ready", bus.req_ready_o, onehot(win));
      r_ppn = PPN_W'($urandom);
      r_fault = 1'($urandom_range(0, 1));
      exp_q.push_back({r_fault, r_ppn, ID_W'(win)});
      next_cycle();
      pend[win] = 1'b0;
      bus.req_valid_i = pend;
      d = $urandom_range(0, 3);
      repeat (d) begin
        #1 check("rnd_issue_v", bus.ptw_req_valid_o, 1);
        check("rnd_issue_vpn", bus.ptw_req_vpn_o, vpns[win]);
        check("rnd_busy_no_ready", bus.req_ready_o, 0);
        next_cycle();
      end
      bus.ptw_req_ready_i = 1'b1;
      #1 check("rnd_issue_vpn_fire", bus.ptw_req_vpn_o, vpns[win]);
      next_cycle();
      bus.ptw_req_ready_i = 1'b0;
      d = $urandom_range(0, 3);
      repeat (d) begin
        #1 check("rnd_wait_r", bus.ptw_resp_ready_o, 1);
        next_cycle();
      end
      bus.ptw_resp_valid_i = 1'b1;
      bus.ptw_resp_ppn_i = r_ppn;
      bus.ptw_resp_fault_i = r_fault;
      #1 check("rnd_wait_r_fire", bus.ptw_resp_ready_o, 1);
      next_cycle();
      bus.ptw_resp_valid_i = 1'b0;
      bus.ptw_resp_ppn_i = PPN_W'($urandom);
      bus.ptw_resp_fault_i = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 2);
      repeat (d) begin
        bus.resp_ready_i = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)) & ~onehot(win);
        #1 check("rnd_resp_hold_v", bus.resp_valid_o, onehot(win));
        check("rnd_resp_hold_ppn", bus.resp_ppn_o, r_ppn);
        check("rnd_resp_hold_fault", bus.resp_fault_o, r_fault);
        next_cycle();
      end
      bus.resp_ready_i = onehot(win) | NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      #1;
      item = exp_q.pop_front();
      check("rnd_resp_v", bus.resp_valid_o, onehot(int'(item[ID_W-1:0])));
      check("rnd_resp_ppn", bus.resp_ppn_o, item[ID_W +: PPN_W]);
      check("rnd_resp_fault", bus.resp_fault_o, item[SB_W-1]);
      next_cycle();
      bus.resp_ready_i = '0;
      #1 check("rnd_idle_busy", busy, 0);
      rr_m = FIXED ? 0 : (win + 1) % NUM_REQ;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  // ---------------- run-time bound ----------------
  initial begin
    #500000;
    tests_run++;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
